// File: rtl/rs_n7k5_err_monitor.sv
// rs_n7k5_err_monitor: registers RS(7,5) decoder-bank payloads, counts errored frames/lanes, tracks FEC lock
//
// Sits after a bank of NUM_DEC parallel RS(7,5) GF(8) decoders and ahead of
// the descrambler. One frame (all lanes) arrives per cycle when dec_valid_i=1.
//
// Optional feature macro: RS_MON_QUALIFY_EN
//   defined   -> data_o / data_valid_o are suppressed (zero) while locked_o=0
//   undefined -> data_o / data_valid_o follow dec_valid_i regardless of lock
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active-low
//   dec_valid_i    decoder outputs carry a frame this cycle
//   dec_msg_i      decoded payloads, lane k at [15k +: 15]
//   dec_err_i      decoder error fields, lane k at [2k +: 2]; non-zero = errored lane
//   cnt_clr_i      synchronous clear of both error counters (wins over a frame)
//   data_o         registered payload (holds when no frame arrives)
//   data_valid_o   data_o carries a frame captured on the last edge
//   frame_err_o    captured frame had at least one errored lane
//   frm_err_cnt_o  saturating count of errored frames
//   lane_err_cnt_o saturating count of errored lanes
//   locked_o       FEC lock status (LOCKED or UNLOCKING)
module rs_n7k5_err_monitor #(
    parameter int NUM_DEC    = 4,
    parameter int CNT_W      = 16,
    parameter int LOCK_THR   = 8,
    parameter int UNLOCK_THR = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid_i,
    input  logic [NUM_DEC*15-1:0]  dec_msg_i,
    input  logic [NUM_DEC*2-1:0]   dec_err_i,
    input  logic                   cnt_clr_i,
    output logic [NUM_DEC*15-1:0]  data_o,
    output logic                   data_valid_o,
    output logic                   frame_err_o,
    output logic [CNT_W-1:0]       frm_err_cnt_o,
    output logic [CNT_W-1:0]       lane_err_cnt_o,
    output logic                   locked_o
);
    localparam int RUN_MAX = (LOCK_THR > UNLOCK_THR) ? LOCK_THR : UNLOCK_THR;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int ERR_W   = $clog2(NUM_DEC + 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, UNLOCKING} stateT;

    stateT                  state;
    logic [RUN_W-1:0]       run;
    logic [RUN_W-1:0]       runInc;
    logic [ERR_W-1:0]       nErr;
    logic                   frameErr;
    logic [NUM_DEC*15-1:0]  dataReg;
    logic                   validReg;
    logic [CNT_W:0]         frmSum;
    logic [CNT_W:0]         laneSum;

    always_comb begin
        nErr = '0;
        for (int k = 0; k < NUM_DEC; k++)
            nErr = nErr + ERR_W'(|dec_err_i[2*k +: 2]);
    end

    assign frameErr = (nErr != '0);
    assign runInc   = run + RUN_W'(1);

    // One extra bit catches the overshoot so the counters clamp instead of wrapping
    assign frmSum  = {1'b0, frm_err_cnt_o}  + (CNT_W+1)'(frameErr);
    assign laneSum = {1'b0, lane_err_cnt_o} + (CNT_W+1)'(nErr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataReg        <= '0;
            validReg       <= 1'b0;
            frame_err_o    <= 1'b0;
            frm_err_cnt_o  <= '0;
            lane_err_cnt_o <= '0;
        end else begin
            validReg    <= dec_valid_i;
            frame_err_o <= dec_valid_i & frameErr;
            if (dec_valid_i)
                dataReg <= dec_msg_i;
            if (cnt_clr_i) begin
                frm_err_cnt_o  <= '0;
                lane_err_cnt_o <= '0;
            end else if (dec_valid_i) begin
                frm_err_cnt_o  <= frmSum[CNT_W]  ? '1 : frmSum[CNT_W-1:0];
                lane_err_cnt_o <= laneSum[CNT_W] ? '1 : laneSum[CNT_W-1:0];
            end
        end
    end

    // Lock FSM: run counts consecutive clean frames while acquiring and
    // consecutive errored frames while losing lock; only valid frames count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            run      <= '0;
            locked_o <= 1'b0;
        end else if (dec_valid_i) begin
            case (state)
                UNLOCKED: begin
                    if (frameErr) begin
                        run <= '0;
                    end else if (LOCK_THR == 1) begin
                        state    <= LOCKED;
                        run      <= '0;
                        locked_o <= 1'b1;
                    end else begin
                        state <= LOCKING;
                        run   <= RUN_W'(1);
                    end
                end
                LOCKING: begin
                    if (frameErr) begin
                        state <= UNLOCKED;
                        run   <= '0;
                    end else if (runInc == RUN_W'(LOCK_THR)) begin
                        state    <= LOCKED;
                        run      <= '0;
                        locked_o <= 1'b1;
                    end else begin
                        run <= runInc;
                    end
                end
                LOCKED: begin
                    if (frameErr && UNLOCK_THR == 1) begin
                        state    <= UNLOCKED;
                        run      <= '0;
                        locked_o <= 1'b0;
                    end else if (frameErr) begin
                        state <= UNLOCKING;
                        run   <= RUN_W'(1);
                    end
                end
                default: begin
                    if (!frameErr) begin
                        state <= LOCKED;
                        run   <= '0;
                    end else if (runInc == RUN_W'(UNLOCK_THR)) begin
                        state    <= UNLOCKED;
                        run      <= '0;
                        locked_o <= 1'b0;
                    end else begin
                        run <= runInc;
                    end
                end
            endcase
        end
    end

`ifdef RS_MON_QUALIFY_EN
    // Gating by the registered lock bit uses the post-edge lock state
    assign data_o       = locked_o ? dataReg : '0;
    assign data_valid_o = validReg & locked_o;
`else
    assign data_o       = dataReg;
    assign data_valid_o = validReg;
`endif

endmodule

// File: tb/tb_rs_n7k5_err_monitor.sv
// tb_rs_n7k5_err_monitor: table, directed and random checks of rs_n7k5_err_monitor against a behavioural model
module tb_rs_n7k5_err_monitor;
    localparam int NUM_DEC    = 4;
    localparam int LOCK_THR   = 8;
    localparam int UNLOCK_THR = 4;
    localparam int DW         = NUM_DEC * 15;
    localparam int EW         = NUM_DEC * 2;
`ifdef RS_MON_QUALIFY_EN
    localparam bit QUAL = 1'b1;
`else
    localparam bit QUAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          decValid = 1'b0;
    logic [DW-1:0] decMsg = '0;
    logic [EW-1:0] decErr = '0;
    logic          cntClr = 1'b0;
    logic [DW-1:0] dataO, satData;
    logic          dataValid, frameErr, locked, satValid, satFrameErr, satLocked;
    logic [15:0]   frmCnt, laneCnt;
    logic [3:0]    satFrm, satLane;

    int nCmp = 0;
    int nBad = 0;

    rs_n7k5_err_monitor #(.NUM_DEC(NUM_DEC), .CNT_W(16), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(decValid), .dec_msg_i(decMsg), .dec_err_i(decErr),
        .cnt_clr_i(cntClr), .data_o(dataO), .data_valid_o(dataValid), .frame_err_o(frameErr),
        .frm_err_cnt_o(frmCnt), .lane_err_cnt_o(laneCnt), .locked_o(locked));

    rs_n7k5_err_monitor #(.NUM_DEC(NUM_DEC), .CNT_W(4), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR)) sat (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(decValid), .dec_msg_i(decMsg), .dec_err_i(decErr),
        .cnt_clr_i(cntClr), .data_o(satData), .data_valid_o(satValid), .frame_err_o(satFrameErr),
        .frm_err_cnt_o(satFrm), .lane_err_cnt_o(satLane), .locked_o(satLocked));

    always #5 clk = ~clk;

    // Behavioural model: lock follows streaks of clean/errored frames
    logic [DW-1:0] mData;
    bit mValid, mFrameErr, mLocked;
    int mStreak, mFrm, mLane, mFrm4, mLane4;

    function automatic int clampTo(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic modelReset();
        mData = '0; mValid = 0; mFrameErr = 0; mLocked = 0; mStreak = 0;
        mFrm = 0; mLane = 0; mFrm4 = 0; mLane4 = 0;
    endtask

    task automatic modelStep(input logic v, input logic [DW-1:0] msg, input logic [EW-1:0] err, input logic clr);
        int nerr;
        nerr = 0;
        for (int k = 0; k < NUM_DEC; k++)
            if (err[2*k +: 2] != 2'b00) nerr++;
        mValid    = v;
        mFrameErr = v && (nerr > 0);
        if (v) begin
            mData = msg;
            if ((nerr == 0) != mLocked) begin
                mStreak++;
                if (mStreak == (mLocked ? UNLOCK_THR : LOCK_THR)) begin
                    mLocked = !mLocked;
                    mStreak = 0;
                end
            end else begin
                mStreak = 0;
            end
        end
        if (clr) begin
            mFrm = 0; mLane = 0; mFrm4 = 0; mLane4 = 0;
        end else if (v) begin
            mFrm   = clampTo(mFrm + ((nerr > 0) ? 1 : 0), 65535);
            mLane  = clampTo(mLane + nerr, 65535);
            mFrm4  = clampTo(mFrm4 + ((nerr > 0) ? 1 : 0), 15);
            mLane4 = clampTo(mLane4 + nerr, 15);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll();
        logic gate;
        gate = QUAL && !mLocked;
        check("data_o", 64'(dataO), gate ? 64'd0 : 64'(mData));
        check("data_valid_o", 64'(dataValid), 64'(mValid && !gate));
        check("frame_err_o", 64'(frameErr), 64'(mFrameErr));
        check("frm_err_cnt_o", 64'(frmCnt), 64'(mFrm));
        check("lane_err_cnt_o", 64'(laneCnt), 64'(mLane));
        check("locked_o", 64'(locked), 64'(mLocked));
        check("sat_frm_cnt", 64'(satFrm), 64'(mFrm4));
        check("sat_lane_cnt", 64'(satLane), 64'(mLane4));
    endtask

    task automatic step(input logic v, input logic [DW-1:0] msg, input logic [EW-1:0] err, input logic clr);
        decValid = v; decMsg = msg; decErr = err; cntClr = clr;
        @(posedge clk);
        modelStep(v, msg, err, clr);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        decValid = 1'b0; cntClr = 1'b0; decErr = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] randMsg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [EW-1:0] randErr(input int pctErr);
        logic [EW-1:0] e;
        e = '0;
        if ($urandom_range(0, 99) < pctErr) begin
            for (int k = 0; k < NUM_DEC; k++) e[2*k +: 2] = 2'($urandom_range(0, 3));
            if (e == '0) e[1:0] = 2'($urandom_range(1, 3));
        end
        return e;
    endfunction

    typedef struct {
        logic          valid;
        logic [DW-1:0] msg;
        logic [EW-1:0] err;
        logic          clr;
        logic          expValid;
        logic          expFrameErr;
        logic          expLocked;
        int            expFrm;
        int            expLane;
    } vecT;

    localparam logic [DW-1:0] PATTERN = 60'h234_5678_9ABC_DEF0;

    vecT vecs[12];

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, DW'(i * 32'h1357_9BDF), '0, 1'b0, 1'b1, 1'b0, (i == 7), 0, 0};
        vecs[8]  = '{1'b1, DW'(32'hCAFE), 8'h31, 1'b0, 1'b1, 1'b1, 1'b1, 1, 2};
        vecs[9]  = '{1'b1, DW'(32'hBEEF), 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        vecs[10] = '{1'b0, DW'(32'h0BAD), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[11] = '{1'b1, PATTERN,       '0,    1'b0, 1'b1, 1'b0, 1'b1, 0, 0};

        doReset();
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_data", 64'(dataO), 64'd0);

        // Table: lock acquisition, counter increment, clear priority, idle hold, data path
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].valid, vecs[i].msg, vecs[i].err, vecs[i].clr);
            check($sformatf("tbl%0d_valid", i), 64'(dataValid), 64'(vecs[i].expValid && !(QUAL && !vecs[i].expLocked)));
            check($sformatf("tbl%0d_frame_err", i), 64'(frameErr), 64'(vecs[i].expFrameErr));
            check($sformatf("tbl%0d_locked", i), 64'(locked), 64'(vecs[i].expLocked));
            check($sformatf("tbl%0d_frm_cnt", i), 64'(frmCnt), 64'(vecs[i].expFrm));
            check($sformatf("tbl%0d_lane_cnt", i), 64'(laneCnt), 64'(vecs[i].expLane));
        end
        check("data_path", 64'(dataO), 64'(PATTERN));

        // 7 clean then 1 errored: no lock, and the run restarts from zero
        doReset();
        for (int i = 0; i < 7; i++) step(1'b1, randMsg(), '0, 1'b0);
        step(1'b1, PATTERN, 8'h04, 1'b0);
        check("no_lock_after_7", 64'(locked), 64'd0);
        check("unlocked_data", 64'(dataO), QUAL ? 64'd0 : 64'(PATTERN));
        check("unlocked_valid", 64'(dataValid), QUAL ? 64'd0 : 64'd1);
        for (int i = 0; i < 7; i++) step(1'b1, randMsg(), '0, 1'b0);
        check("restart_not_locked", 64'(locked), 64'd0);
        step(1'b1, randMsg(), '0, 1'b0);
        check("restart_locked", 64'(locked), 64'd1);

        // Unlock: 3 errored, 1 clean, then 4 errored
        for (int i = 0; i < 3; i++) begin
            step(1'b1, randMsg(), 8'h40, 1'b0);
            check($sformatf("unlock_hold_%0d", i), 64'(locked), 64'd1);
        end
        step(1'b1, randMsg(), '0, 1'b0);
        check("unlock_clean_break", 64'(locked), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, randMsg(), 8'h02, 1'b0);
            check($sformatf("unlock_run_%0d", i), 64'(locked), (i == 3) ? 64'd0 : 64'd1);
        end

        // Asynchronous reset between edges
        for (int i = 0; i < 8; i++) step(1'b1, randMsg(), '0, 1'b0);
        step(1'b1, randMsg(), 8'hC3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the narrow counters: lane count 14 + 3 clamps to 15
        doReset();
        for (int i = 0; i < 3; i++) step(1'b1, randMsg(), 8'hFF, 1'b0);
        step(1'b1, randMsg(), 8'h05, 1'b0);
        check("sat_pre_lane", 64'(satLane), 64'd14);
        step(1'b1, randMsg(), 8'h15, 1'b0);
        check("sat_lane_clamp", 64'(satLane), 64'd15);
        check("sat_frm_5", 64'(satFrm), 64'd5);
        check("wide_lane_17", 64'(laneCnt), 64'd17);
        step(1'b1, randMsg(), 8'hFF, 1'b0);
        check("sat_lane_hold", 64'(satLane), 64'd15);

        // Random traffic with varying error density
        doReset();
        for (int i = 0; i < 600; i++) begin
            int pct;
            pct = (i >= 200 && i < 300) ? 60 : 12;
            step($urandom_range(0, 9) < 7, randMsg(), randErr(pct), $urandom_range(0, 99) < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
